// File: rtl/gb80_pkg.sv
// Shared widths, M-cycle length and bus op encodings for the gb80 memory-side bus.
package gb80_pkg;
   localparam int GB80_T_PER_M = 4;
   localparam int GB80_ADDR_W  = 16;
   localparam int GB80_DATA_W  = 8;

   localparam logic BUS_RD = 1'b0;
   localparam logic BUS_WR = 1'b1;
endpackage

// File: rtl/gb80_tcycle_counter.sv
// T-state phase counter: i_start enters phase 0 next cycle, free-runs to T_PER_M-1, then idles.
// Zero-latency outputs from registered state; no backpressure, a restart is only honoured when the caller allows it.
module gb80_tcycle_counter
   import gb80_pkg::*;
#(
   parameter int T_PER_M = GB80_T_PER_M
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   output logic                       o_active,
   output logic [$clog2(T_PER_M)-1:0] o_phase,
   output logic                       o_last
);
   localparam int              PH_W    = $clog2(T_PER_M);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_PER_M - 1);

   logic            active_q, active_d;
   logic [PH_W-1:0] phase_q, phase_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         active_q <= 1'b0;
         phase_q  <= '0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
      end
   end

   // Wrap only through a restart or IDLE; the phase never runs past the last T-state.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      if (i_start) begin
         active_d = 1'b1;
         phase_d  = '0;
      end else if (active_q && (phase_q == PH_LAST)) begin
         active_d = 1'b0;
         phase_d  = '0;
      end else if (active_q) begin
         phase_d  = phase_q + 1'b1;
      end
   end

   always_comb begin
      o_active = active_q;
      o_phase  = phase_q;
      o_last   = active_q && (phase_q == PH_LAST);
   end
endmodule

// File: rtl/gb80_bus_controller.sv
// M-cycle bus sequencer: one core request becomes a T_PER_M-clock memory access; ack in the final T-state.
// Accepts only when idle or in the final T-state; i_hold or a busy cycle leaves i_req pending (core holds it).
module gb80_bus_controller
   import gb80_pkg::*;
#(
   parameter int T_PER_M = GB80_T_PER_M,
   parameter int ADDR_W  = GB80_ADDR_W,
   parameter int DATA_W  = GB80_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_hold,
   output logic              o_ready,
   output logic              o_ack,
   output logic [DATA_W-1:0] o_rdata,
   output logic [ADDR_W-1:0] o_memory_addr,
   output logic              o_memory_rd,
   output logic              o_memory_wr,
   output logic [DATA_W-1:0] o_memory_wdata,
   input  logic [DATA_W-1:0] i_memory_data
);
   localparam int              PH_W   = $clog2(T_PER_M);
   localparam logic [PH_W-1:0] PH_CAP = PH_W'(T_PER_M - 2);

   logic            active;
   logic            last;
   logic [PH_W-1:0] phase;
   logic            accept;
   logic            capture;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   gb80_tcycle_counter #(
      .T_PER_M (T_PER_M)
   ) u_tcycle (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_start  (accept),
      .o_active (active),
      .o_phase  (phase),
      .o_last   (last)
   );

   // Hold wins over a simultaneous request at the accept point.
   assign o_ready = !active || last;
   assign accept  = o_ready && i_req && !i_hold;
   assign capture = active && (we_q == BUS_RD) && (phase == PH_CAP);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         we_q    <= BUS_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         we_d    = i_we;
         addr_d  = i_addr;
         wdata_d = i_wdata;
      end
      if (capture) begin
         rdata_d = i_memory_data;
      end
   end

   // Write strobe opens a T-state after the address so the memory sees a setup margin.
   always_comb begin
      o_memory_addr  = addr_q;
      o_memory_wdata = wdata_q;
      o_rdata        = rdata_q;
      o_ack          = last;
      o_memory_rd    = active && (we_q == BUS_RD) && (phase <= PH_CAP);
      o_memory_wr    = active && (we_q == BUS_WR) && (phase != '0) && (phase <= PH_CAP);
   end
endmodule

// File: tb/tb_gb80_bus_controller.sv
// Directed and randomized bench for gb80_bus_controller against a transaction-level reference.
module tb_gb80_bus_controller;
   import gb80_pkg::*;

   localparam int T = GB80_T_PER_M;

   logic        clk = 1'b0;
   logic        reset, req, we, hold;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        o_ready, o_ack, o_memory_rd, o_memory_wr;
   logic [7:0]  o_rdata, o_memory_wdata, mem_data;
   logic [15:0] o_memory_addr;

   always #5 clk = ~clk;

   gb80_bus_controller dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_req          (req),
      .i_we           (we),
      .i_addr         (addr),
      .i_wdata        (wdata),
      .i_hold         (hold),
      .o_ready        (o_ready),
      .o_ack          (o_ack),
      .o_rdata        (o_rdata),
      .o_memory_addr  (o_memory_addr),
      .o_memory_rd    (o_memory_rd),
      .o_memory_wr    (o_memory_wr),
      .o_memory_wdata (o_memory_wdata),
      .i_memory_data  (mem_data)
   );

   // Memory device: preload port for the bench, write port for the DUT.
   logic [7:0]  mem [0:65535];
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;
   assign mem_data = mem[o_memory_addr];
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (o_memory_wr) mem[o_memory_addr] <= o_memory_wdata;
   end

   // Reference: golden memory plus the current transfer and its age in clocks since acceptance.
   logic [7:0]  gold [0:65535];
   int          m_age;
   logic        m_we;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata, m_rdata;

   int n_pass = 0, n_fail = 0, n_chk = 0;
   int obs_cyc, rd_cnt, wr_cnt, wr_first, gap_cnt, acc_cnt;
   int ack_q[$];
   bit last_acc;

   function automatic bit e_ready();
      return (m_age < 0) || (m_age == T - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clr_obs();
      obs_cyc = 0; rd_cnt = 0; wr_cnt = 0; wr_first = 0; gap_cnt = 0; acc_cnt = 0;
      ack_q.delete();
   endtask

   task automatic cycle();
      bit acc, rst;
      rst = reset;
      acc = !rst && e_ready() && req && !hold;
      @(posedge clk);
      #1;
      if (rst) begin
         m_age = -1; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else begin
         if (m_age == T - 2 && !m_we) m_rdata = gold[m_addr];
         if (m_age == T - 1 && m_we)  gold[m_addr] = m_wdata;
         if (acc) begin
            m_age = 0; m_we = we; m_addr = addr; m_wdata = wdata;
         end else if (m_age == T - 1) m_age = -1;
         else if (m_age >= 0)         m_age++;
      end
      last_acc = acc;
      if (acc) acc_cnt++;
      obs_cyc++;
      chk("ready", o_ready, e_ready());
      chk("ack", o_ack, m_age == T - 1);
      chk("rd", o_memory_rd, m_age >= 0 && m_age <= T - 2 && !m_we);
      chk("wr", o_memory_wr, m_age >= 1 && m_age <= T - 2 && m_we);
      chk("addr", o_memory_addr, m_addr);
      chk("wdata", o_memory_wdata, m_wdata);
      chk("rdata", o_rdata, m_rdata);
      chk("strobe_excl", o_memory_rd && o_memory_wr, 0);
      if (o_memory_rd) rd_cnt++;
      if (o_memory_wr) begin
         wr_cnt++;
         if (wr_first == 0) wr_first = obs_cyc;
      end
      if (o_ack) ack_q.push_back(obs_cyc);
      if (o_ready && !o_ack && ack_q.size() > 0 && ack_q.size() < 3) gap_cnt++;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d; gold[a] = d;
      cycle();
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      for (int k = 0; k < 20 && !last_acc; k++) cycle();
   endtask

   initial begin
      m_age = -1; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      reset = 1'b1; req = 1'b0; we = 1'b0; hold = 1'b0; addr = '0; wdata = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      clr_obs();
      last_acc = 1'b0;

      // Preload while reset is held.
      preload(16'h0150, 8'hAA);
      preload(16'h0100, 8'h11);
      preload(16'h0102, 8'h22);
      preload(16'h0200, 8'h5A);
      preload(16'h0300, 8'h00);
      for (int i = 0; i < 32; i++) preload(16'h0400 + 16'(i), 8'($urandom));

      // 1: reset for 6 clocks, then idle with no request.
      for (int i = 0; i < 6; i++) cycle();
      chk("t1_rst_ready", o_ready, 1);
      chk("t1_rst_addr", o_memory_addr, 16'h0000);
      chk("t1_rst_rdwr", {o_memory_rd, o_memory_wr, o_ack}, 3'b000);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("t1_idle_ready", o_ready, 1);
      chk("t1_idle_rd", o_memory_rd, 0);

      // 2: single read of 0x0150.
      clr_obs(); last_acc = 1'b0;
      issue(1'b0, 16'h0150, 8'h00);
      chk("t2_acc", last_acc, 1);
      req = 1'b0; addr = 16'h0BAD;
      for (int i = 0; i < 6; i++) cycle();
      chk("t2_rd_cnt", rd_cnt, 3);
      chk("t2_wr_cnt", wr_cnt, 0);
      chk("t2_ack_cnt", ack_q.size(), 1);
      chk("t2_ack_pos", (ack_q.size() > 0) ? ack_q[0] : -1, 4);
      chk("t2_rdata", o_rdata, 8'hAA);

      // 3: single write 0xC000 <- 0x3E.
      clr_obs(); last_acc = 1'b0;
      issue(1'b1, 16'hC000, 8'h3E);
      chk("t3_acc", last_acc, 1);
      req = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("t3_wr_cnt", wr_cnt, 2);
      chk("t3_wr_first", wr_first, 2);
      chk("t3_rd_cnt", rd_cnt, 0);
      chk("t3_ack_pos", (ack_q.size() > 0) ? ack_q[0] : -1, 4);
      chk("t3_rdata", o_rdata, 8'hAA);
      chk("t3_mem", mem[16'hC000], 8'h3E);

      // 4: back-to-back read, write, read with i_req held throughout.
      clr_obs(); last_acc = 1'b0;
      issue(1'b0, 16'h0100, 8'h00);
      chk("t4_acc0", last_acc, 1);
      last_acc = 1'b0;
      issue(1'b1, 16'h0101, 8'h77);
      chk("t4_acc1", last_acc, 1);
      last_acc = 1'b0;
      issue(1'b0, 16'h0102, 8'h00);
      chk("t4_acc2", last_acc, 1);
      req = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("t4_ack_cnt", ack_q.size(), 3);
      chk("t4_gap01", (ack_q.size() > 1) ? ack_q[1] - ack_q[0] : -1, 4);
      chk("t4_gap12", (ack_q.size() > 2) ? ack_q[2] - ack_q[1] : -1, 4);
      chk("t4_idle_gap", gap_cnt, 0);
      chk("t4_rdata", o_rdata, 8'h22);
      chk("t4_mem", mem[16'h0101], 8'h77);

      // 5: hold raised in phase 1 of a read; next request waits for hold release.
      clr_obs(); last_acc = 1'b0;
      issue(1'b0, 16'h0150, 8'h00);
      req = 1'b0;
      cycle();
      hold = 1'b1;
      req = 1'b1; we = 1'b0; addr = 16'h0100;
      for (int i = 0; i < 7; i++) cycle();
      chk("t5_ack_during_hold", ack_q.size(), 1);
      chk("t5_no_accept", acc_cnt, 1);
      chk("t5_idle_rd", o_memory_rd, 0);
      hold = 1'b0;
      cycle();
      chk("t5_accept_on_release", last_acc, 1);
      chk("t5_rd_after_release", o_memory_rd, 1);
      req = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("t5_ack_total", ack_q.size(), 2);
      chk("t5_rdata", o_rdata, 8'h11);

      // 6: reset in phase 2 of a read aborts it; a preceding read leaves o_rdata at 0x00.
      last_acc = 1'b0;
      issue(1'b0, 16'h0300, 8'h00);
      req = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("t6_pre_rdata", o_rdata, 8'h00);
      clr_obs(); last_acc = 1'b0;
      issue(1'b0, 16'h0200, 8'h00);
      req = 1'b0;
      cycle();
      cycle();
      chk("t6_in_phase2_rd", o_memory_rd, 1);
      reset = 1'b1;
      cycle();
      chk("t6_strobes_drop", {o_memory_rd, o_memory_wr}, 2'b00);
      chk("t6_no_ack_rst", o_ack, 0);
      chk("t6_rdata_kept", o_rdata, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("t6_no_ack", ack_q.size(), 0);
      chk("t6_ready", o_ready, 1);

      // 7: randomized traffic, hold and occasional reset against the reference.
      clr_obs();
      req = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!req || last_acc) begin
            req   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom);
            addr  = 16'h0400 + 16'($urandom_range(0, 31));
            wdata = 8'($urandom);
         end
         hold  = ($urandom_range(0, 4) == 0);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0; hold = 1'b0; req = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("t7_some_acks", ack_q.size() > 20, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
